// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control unit: FSM sequencing fetch/decode/execute/memory/writeback
// with a sticky illegal-opcode flag and a retired-instruction counter.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_rdy,
  output logic        pc_we,
  output logic        ir_we,
  output logic        rf_we,
  output logic        dm_re,
  output logic        dm_we,
  output logic [1:0]  reg_dst,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic [1:0]  mem_to_reg,
  output logic [1:0]  npc_sel,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXE     = 4'd2,
    S_MEM_ADR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_WB      = 4'd6,
    S_BR      = 4'd7,
    S_JMP     = 4'd8,
    S_ERR     = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_BAD
  } ins_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  function automatic ins_t classify(input logic [5:0] op, input logic [5:0] fn);
    ins_t c;
    c = I_BAD;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU: c = I_ADDU;
          FN_SUBU: c = I_SUBU;
          FN_JR:   c = I_JR;
          default: c = I_BAD;
        endcase
      end
      OP_ORI:  c = I_ORI;
      OP_LUI:  c = I_LUI;
      OP_LW:   c = I_LW;
      OP_SW:   c = I_SW;
      OP_BEQ:  c = I_BEQ;
      OP_J:    c = I_J;
      OP_JAL:  c = I_JAL;
      default: c = I_BAD;
    endcase
    return c;
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_opcode;
  logic [5:0]  r_funct;
  logic        r_illegal;
  logic [31:0] r_retired;
  ins_t        w_live_ins;
  ins_t        w_ins;
  logic        w_retire;
  logic        w_pc_we, w_ir_we, w_rf_we, w_dm_re, w_dm_we;

  // Only DECODE looks at the live instruction bits; every later state uses the latched copy.
  assign w_live_ins = classify(opcode, funct);
  assign w_ins      = classify(r_opcode, r_funct);

  always_comb begin
    w_state_next = r_state;
    w_pc_we      = 1'b0;
    w_ir_we      = 1'b0;
    w_rf_we      = 1'b0;
    w_dm_re      = 1'b0;
    w_dm_we      = 1'b0;
    reg_dst      = 2'd0;
    alu_src      = 1'b0;
    alu_op       = 2'd0;
    mem_to_reg   = 2'd0;
    npc_sel      = 2'd0;
    case (r_state)
      S_FETCH: begin
        w_ir_we      = 1'b1;
        w_pc_we      = 1'b1;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_live_ins)
          I_ADDU, I_SUBU, I_ORI, I_LUI: w_state_next = S_EXE;
          I_LW, I_SW:                   w_state_next = S_MEM_ADR;
          I_BEQ:                        w_state_next = S_BR;
          I_J, I_JAL, I_JR:             w_state_next = S_JMP;
          default:                      w_state_next = S_ERR;
        endcase
      end
      S_EXE: begin
        case (w_ins)
          I_SUBU:  alu_op = 2'd1;
          I_ORI: begin
            alu_op  = 2'd2;
            alu_src = 1'b1;
          end
          I_LUI: begin
            alu_op  = 2'd3;
            alu_src = 1'b1;
          end
          default: alu_op = 2'd0;
        endcase
        w_state_next = S_WB;
      end
      S_MEM_ADR: begin
        alu_src      = 1'b1;
        w_state_next = (w_ins == I_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_dm_re = 1'b1;
        if (mem_rdy) w_state_next = S_WB;
      end
      S_MEM_WR: begin
        w_dm_we = 1'b1;
        if (mem_rdy) w_state_next = S_FETCH;
      end
      S_WB: begin
        w_rf_we = 1'b1;
        case (w_ins)
          I_ADDU, I_SUBU: reg_dst    = 2'd1;
          I_LW:           mem_to_reg = 2'd1;
          default:        reg_dst    = 2'd0;
        endcase
        w_state_next = S_FETCH;
      end
      S_BR: begin
        alu_op       = 2'd1;
        npc_sel      = 2'd1;
        w_pc_we      = zero;
        w_state_next = S_FETCH;
      end
      S_JMP: begin
        w_pc_we = 1'b1;
        case (w_ins)
          I_JR:  npc_sel = 2'd3;
          I_JAL: begin
            npc_sel    = 2'd2;
            w_rf_we    = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
          end
          default: npc_sel = 2'd2;
        endcase
        w_state_next = S_FETCH;
      end
      S_ERR:   w_state_next = S_ERR;
      default: w_state_next = S_ERR;
    endcase
  end

  // Reset masks the strobes immediately, even mid-wait, so no stray access escapes.
  assign pc_we = w_pc_we & ~reset;
  assign ir_we = w_ir_we & ~reset;
  assign rf_we = w_rf_we & ~reset;
  assign dm_re = w_dm_re & ~reset;
  assign dm_we = w_dm_we & ~reset;

  assign w_retire = (w_state_next == S_FETCH) && (r_state != S_FETCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_opcode  <= 6'd0;
      r_funct   <= 6'd0;
      r_illegal <= 1'b0;
      r_retired <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_DECODE) begin
        r_opcode <= opcode;
        r_funct  <= funct;
      end
      if (w_state_next == S_ERR) r_illegal <= 1'b1;
      r_retired <= r_retired + {31'd0, w_retire};
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous reset, active-high.
REQ-004 opcode  in  6  instr[31:26]; valid from DECODE onward.
REQ-005 funct  in  6  instr[5:0]; valid from DECODE onward.
REQ-006 zero  in  1  ALU equal flag.
REQ-007 mem_rdy  in  1  data-memory handshake: access completes on the cycle it is high.
REQ-008 pc_we, ir_we, rf_we, dm_re, dm_we  out  1 each  PC/IR/regfile write, dmem read/write strobes.
REQ-009 reg_dst  out  2  select: 0=rt, 1=rd, 2=$31.
REQ-010 alu_src  out  1  select: 0=rt data, 1=extended imm.
REQ-011 alu_op  out  2  operation: 0=add, 1=sub, 2=or, 3=lui.
REQ-012 mem_to_reg  out  2  select: 0=ALU, 1=mem, 2=PC+4.
REQ-013 npc_sel  out  2  select: 0=PC+4, 1=branch, 2=j-target, 3=rs.
REQ-014 state  out  4  current state code; illegal  out  1  sticky illegal-op flag; retired  out  32  instruction counter.

Function
REQ-015 States and codes SHALL be FETCH=0, DECODE=1, EXE=2, MEM_ADR=3, MEM_RD=4, MEM_WR=5, WB=6, BR=7, JMP=8, ERR=9.
REQ-016 Supported ops SHALL be R-type (op 000000) addu (funct 100001), subu (100011) and jr (001000); ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
REQ-017 FETCH SHALL assert ir_we=1, pc_we=1 and npc_sel=0, then go to DECODE.
REQ-018 DECODE SHALL latch opcode/funct internally; all later states SHALL use the latched copy.
REQ-019 DECODE SHALL branch as follows:
- addu/subu/ori/lui -> EXE
- lw/sw -> MEM_ADR
- beq -> BR
- j/jal/jr -> JMP
- any other op/funct -> ERR
REQ-020 EXE SHALL drive alu_op and alu_src per op, then go to WB:
- addu: alu_op=0, alu_src=0
- subu: alu_op=1, alu_src=0
- ori: alu_op=2, alu_src=1
- lui: alu_op=3, alu_src=1
REQ-021 WB SHALL assert rf_we=1 for one cycle, then go to FETCH:
- R-type: reg_dst=1, mem_to_reg=0
- ori/lui: reg_dst=0, mem_to_reg=0
- lw: reg_dst=0, mem_to_reg=1
REQ-022 MEM_ADR SHALL drive alu_op=0 and alu_src=1, then go to MEM_RD (lw) or MEM_WR (sw).
REQ-023 MEM_RD SHALL hold dm_re=1 and stay in MEM_RD while mem_rdy=0; on mem_rdy=1 it SHALL go to WB.
REQ-024 MEM_WR SHALL hold dm_we=1 and stay in MEM_WR while mem_rdy=0; on mem_rdy=1 it SHALL go to FETCH.
REQ-025 mem_rdy SHALL be ignored in every state except MEM_RD and MEM_WR.
REQ-026 BR SHALL drive alu_op=1, alu_src=0, npc_sel=1 and pc_we=zero, then go to FETCH.
REQ-027 JMP SHALL assert pc_we=1, then go to FETCH:
- j: npc_sel=2
- jr: npc_sel=3
- jal: npc_sel=2, plus rf_we=1, reg_dst=2, mem_to_reg=2 in the same cycle
REQ-028 ERR SHALL set illegal=1, hold all enables at 0 and remain in ERR until reset.
REQ-029 Any output not specified for a state SHALL be 0 in that state.
REQ-030 All outputs SHALL be combinational functions of state and the latched op only; no input SHALL reach an output combinationally except zero -> pc_we in BR.
REQ-031 retired SHALL increment by 1 on each transition into FETCH from any state other than FETCH.
REQ-032 retired SHALL wrap from 0xFFFFFFFF to 0.
REQ-033 Cycle counts per instruction (mem_rdy high immediately): R/ori/lui 4, lw 5, sw 4, beq 3, j/jal/jr 3; each extra mem_rdy=0 cycle SHALL add 1.

Reset
REQ-034 When reset=1 at a clock edge, the block SHALL go to FETCH and clear illegal, retired and the latched op to 0.
REQ-035 While reset=1, all write/read enables SHALL be forced to 0 regardless of state.
REQ-036 Reset SHALL take priority in every state, including mid MEM_RD/MEM_WR wait and ERR.

Verification
REQ-037 Bench SHALL run: reset, then addu (op 0, funct 21h) -> states 0,1,2,6,0; rf_we=1 only in WB with reg_dst=1; retired=1.
REQ-038 Bench SHALL run: lw with mem_rdy low for 3 cycles in MEM_RD -> dm_re high for 4 cycles, then WB with mem_to_reg=1; total 8 cycles.
REQ-039 Bench SHALL run: beq with zero=0, then with zero=1 -> pc_we=0 in BR, then pc_we=1 with npc_sel=1.
REQ-040 Bench SHALL run: jal -> in JMP, pc_we=1, rf_we=1, reg_dst=2, mem_to_reg=2, npc_sel=2 in one cycle.
REQ-041 Bench SHALL run: opcode 3Fh -> ERR; illegal=1 held for 10 cycles with all enables 0; reset -> FETCH, illegal=0.
REQ-042 Bench SHALL run: reset asserted while in MEM_WR waiting -> dm_we=0 in that cycle and state=0 after the edge; preload retired=FFFFFFFFh, retire one instruction -> retired=0.
